// File: rtl/l2_pkg.sv
// l2_pkg: shared defaults and record types for the L2 bank request front-end.
//   L2_*            default widths/depths used by l2_bank_ctrl and its interface
//   l2_req_t        queued request record {wr, addr, wdata, tag} at default widths
//   l2_rsp_t        queued read response record {rdata, tag} at default widths
//   l2_cnt_width()  occupancy counter width for a queue of the given depth
package l2_pkg;

    localparam int unsigned L2_ADDR_WIDTH = 40;
    localparam int unsigned L2_DATA_WIDTH = 64;
    localparam int unsigned L2_TAG_WIDTH  = 8;
    localparam int unsigned L2_REQ_DEPTH  = 4;
    localparam int unsigned L2_RSP_DEPTH  = 4;

    typedef struct packed {
        logic                     wr;
        logic [L2_ADDR_WIDTH-1:0] addr;
        logic [L2_DATA_WIDTH-1:0] wdata;
        logic [L2_TAG_WIDTH-1:0]  tag;
    } l2_req_t;

    typedef struct packed {
        logic [L2_DATA_WIDTH-1:0] rdata;
        logic [L2_TAG_WIDTH-1:0]  tag;
    } l2_rsp_t;

    // A queue of DEPTH entries must be able to represent 0..DEPTH inclusive.
    function automatic int unsigned l2_cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/l2_bank_ctrl_if.sv
// l2_bank_ctrl_if: bundles the request channel, response channel, bank port
// and error flag of one L2 bank front-end.
//   slave  : the controller's view (accepts requests, drives responses/bank)
//   master : the surrounding view (crossbar side + bank model)
interface l2_bank_ctrl_if
    import l2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = L2_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = L2_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = L2_TAG_WIDTH
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [TAG_WIDTH-1:0]  req_tag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [TAG_WIDTH-1:0]  rsp_tag;

    logic                  bank_en;
    logic                  bank_wr;
    logic [ADDR_WIDTH-1:0] bank_addr;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [DATA_WIDTH-1:0] bank_rdata;
    logic                  bank_ready;

    logic                  err_no_ready;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_tag,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_tag,
        input  rsp_ready,
        output bank_en, bank_wr, bank_addr, bank_wdata,
        input  bank_rdata, bank_ready,
        output err_no_ready
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_tag,
        output rsp_ready,
        input  bank_en, bank_wr, bank_addr, bank_wdata,
        output bank_rdata, bank_ready,
        input  err_no_ready
    );

endinterface

// File: rtl/l2_fifo.sv
// l2_fifo: synchronous FIFO, no empty bypass, asynchronous active-high reset.
//   clk, rst     : clock / async reset (clears pointers, count and storage)
//   push, din    : write when not full
//   pop, dout    : read when not empty; dout shows the head entry
//   full, empty  : occupancy flags
//   count        : entries held, 0..DEPTH
module l2_fifo
    import l2_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [WIDTH-1:0]                  din,
    input  logic                              pop,
    output logic [WIDTH-1:0]                  dout,
    output logic                              full,
    output logic                              empty,
    output logic [l2_cnt_width(DEPTH)-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = l2_cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l2_bank_ctrl.sv
// l2_bank_ctrl: in-order request front-end for one L2 bank.
//   clk, rst : clock / async active-high reset
//   bus      : l2_bank_ctrl_if.slave
//     req_*      tagged read/write request channel (valid/ready)
//     rsp_*      tagged read response channel (valid/ready)
//     bank_*     bank SRAM port; bank_ready/bank_rdata one cycle after bank_en
//     err_no_ready sticky: bank missed an expected bank_ready
module l2_bank_ctrl
    import l2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = L2_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = L2_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = L2_TAG_WIDTH,
    parameter int unsigned REQ_DEPTH  = L2_REQ_DEPTH,
    parameter int unsigned RSP_DEPTH  = L2_RSP_DEPTH
) (
    input logic           clk,
    input logic           rst,
    l2_bank_ctrl_if.slave bus
);

    localparam int unsigned RQCW = l2_cnt_width(REQ_DEPTH);
    localparam int unsigned RSCW = l2_cnt_width(RSP_DEPTH);
    localparam int unsigned UW   = RSCW + 1;

    // Local records track the instance widths; l2_pkg types fix the defaults.
    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [TAG_WIDTH-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic [TAG_WIDTH-1:0]  tag;
    } rsp_t;

    req_t            req_in;
    req_t            req_head;
    logic            req_push;
    logic            req_full;
    logic            req_empty;
    logic [RQCW-1:0] req_count;

    rsp_t            rsp_in;
    rsp_t            rsp_head;
    logic            rsp_push;
    logic            rsp_pop;
    logic            rsp_full;
    logic            rsp_empty;
    logic [RSCW-1:0] rsp_count;

    logic            issue;
    logic            rd_credit;
    logic [UW-1:0]   rd_used;

    logic                 ifl_valid;
    logic                 ifl_rd;
    logic [TAG_WIDTH-1:0] ifl_tag;
    logic                 inflight_rd;
    logic                 err_q;

    // ---------------- request queue ----------------
    assign req_in = '{wr: bus.req_wr, addr: bus.req_addr,
                      wdata: bus.req_wdata, tag: bus.req_tag};
    assign bus.req_ready = !req_full;
    assign req_push      = bus.req_valid && !req_full;

    l2_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_q (
        .clk   (clk),
        .rst   (rst),
        .push  (req_push),
        .din   (req_in),
        .pop   (issue),
        .dout  (req_head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    // ---------------- issue ----------------
    // Read credit counts queued responses plus a read awaiting completion;
    // a response leaving this cycle is only reflected next cycle.
    assign inflight_rd = ifl_valid && ifl_rd;
    assign rd_used     = UW'(rsp_count) + UW'(inflight_rd);
    assign rd_credit   = rd_used < UW'(RSP_DEPTH);
    assign issue       = !req_empty && (req_head.wr || rd_credit);

    assign bus.bank_en    = issue;
    assign bus.bank_wr    = issue && req_head.wr;
    assign bus.bank_addr  = req_head.addr;
    assign bus.bank_wdata = req_head.wdata;

    // ---------------- in-flight / completion ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifl_valid <= 1'b0;
            ifl_rd    <= 1'b0;
            ifl_tag   <= '0;
        end else begin
            ifl_valid <= issue;
            ifl_rd    <= issue && !req_head.wr;
            ifl_tag   <= req_head.tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (ifl_valid && !bus.bank_ready) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_no_ready = err_q;

    // ---------------- response queue ----------------
    assign rsp_push = inflight_rd && bus.bank_ready;
    assign rsp_in   = '{rdata: bus.bank_rdata, tag: ifl_tag};
    assign rsp_pop  = !rsp_empty && bus.rsp_ready;

    l2_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_q (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .din   (rsp_in),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign bus.rsp_valid = !rsp_empty;
    assign bus.rsp_rdata = rsp_head.rdata;
    assign bus.rsp_tag   = rsp_head.tag;

    // Credit accounting guarantees the response queue never overflows.
    a_rsp_no_overflow: assert property (@(posedge clk) disable iff (rst)
        rsp_push |-> !rsp_full);
    a_req_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        req_count <= RQCW'(REQ_DEPTH));

endmodule
